// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
//   REG_IDX_W / DATA_W : register index and data widths
//   SEQW               : age-stamp width (2^(SEQW-1) must exceed 2*QDEPTH+1)
//   SRC_ALU / SRC_MEM  : source indices (src0 = ALU result, src1 = memory load)
//   wb_entry_t         : queued write {destination, value, age stamp}
//   is_older()         : wrap-safe age comparison
package regfile_wb_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int SEQW      = 4;
    localparam int SRC_ALU   = 0;
    localparam int SRC_MEM   = 1;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
        logic [SEQW-1:0]      stamp;
    } wb_entry_t;

    // a is older than b when (a - b) wraps negative
    function automatic logic is_older(input logic [SEQW-1:0] a, input logic [SEQW-1:0] b);
        logic [SEQW-1:0] diff;
        diff = a - b;
        return diff[SEQW-1];
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback sources, the register file write port
// and the forwarding lookup.
//   master : source/consumer side (drives Src*_valid/reg/data and Query_reg)
//   slave  : arbiter side (drives Src*_ready, Write_*, Query_hit/data, Busy)
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                 Src0_valid;
    logic                 Src0_ready;
    logic [REG_IDX_W-1:0] Src0_reg;
    logic [DATA_W-1:0]    Src0_data;
    logic                 Src1_valid;
    logic                 Src1_ready;
    logic [REG_IDX_W-1:0] Src1_reg;
    logic [DATA_W-1:0]    Src1_data;
    logic                 Write_en;
    logic [REG_IDX_W-1:0] Write_reg;
    logic [DATA_W-1:0]    Write_data;
    logic [REG_IDX_W-1:0] Query_reg;
    logic                 Query_hit;
    logic [DATA_W-1:0]    Query_data;
    logic                 Busy;

    modport master (
        output Src0_valid, Src0_reg, Src0_data,
        output Src1_valid, Src1_reg, Src1_data,
        output Query_reg,
        input  Src0_ready, Src1_ready,
        input  Write_en, Write_reg, Write_data,
        input  Query_hit, Query_data, Busy
    );

    modport slave (
        input  Src0_valid, Src0_reg, Src0_data,
        input  Src1_valid, Src1_reg, Src1_data,
        input  Query_reg,
        output Src0_ready, Src1_ready,
        output Write_en, Write_reg, Write_data,
        output Query_hit, Query_data, Busy
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_age_fifo.sv
// wb_age_fifo: circular per-source queue of age-stamped writes.
//   Clk, Rst        : clock, synchronous active-high reset
//   Clr             : synchronous discard of all entries
//   push/push_entry : enqueue (ignored when full)
//   pop             : dequeue head (ignored when empty)
//   head/full/empty : head entry and occupancy flags
//   entries/valid   : every slot and its occupancy, for the forwarding search
module wb_age_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] offset;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign entries = mem;

    always_ff @(posedge Clk) begin
        if (Rst || Clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push && !Rst && !Clr) mem[wr_ptr] <= push_entry;
    end

    // A slot is live when its distance from the head is below the count;
    // DEPTH is a power of two so the subtraction wraps correctly.
    always_comb begin
        offset = '0;
        valid  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PTR_W'(i) - rd_ptr;
            valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the ALU
// result (src0) and the memory load (src1). Each source feeds an age-stamped
// queue; every cycle the older head moves into a registered write stage.
//   Clk, Rst : clock, synchronous active-high reset
//   Flush    : synchronous discard of all pending writes
//   bus      : source handshakes, register-file write port, forwarding
//              lookup (Query_*) and Busy
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Flush,
    regfile_wb_arbiter_if.slave  bus
);

    logic [SEQW-1:0]      age_cnt;
    logic                 rdy0, rdy1, acc0, acc1;
    wb_entry_t            ent0, ent1;
    wb_entry_t            head [2];
    wb_entry_t            entries0 [QDEPTH];
    wb_entry_t            entries1 [QDEPTH];
    logic [QDEPTH-1:0]    valid0, valid1;
    logic [1:0]           full, empty;
    logic                 grant_mem, pop_mem, pop_alu;
    logic                 wr_en;
    logic [REG_IDX_W-1:0] wr_reg;
    logic [DATA_W-1:0]    wr_data;
    logic                 q_hit, q_from_queue;
    logic [DATA_W-1:0]    q_data;
    logic [SEQW-1:0]      q_stamp;

    assign rdy0 = !Rst && !Flush && !full[SRC_ALU];
    assign rdy1 = !Rst && !Flush && !full[SRC_MEM];
    // Writes to r0 complete the handshake but are dropped here
    assign acc0 = bus.Src0_valid && rdy0 && (bus.Src0_reg != '0);
    assign acc1 = bus.Src1_valid && rdy1 && (bus.Src1_reg != '0);

    // The load is the older instruction when both arrive together
    assign ent1 = '{rd: bus.Src1_reg, data: bus.Src1_data, stamp: age_cnt};
    assign ent0 = '{rd: bus.Src0_reg, data: bus.Src0_data, stamp: age_cnt + SEQW'(acc1)};

    wb_age_fifo #(.DEPTH(QDEPTH)) u_q_alu (
        .Clk(Clk), .Rst(Rst), .Clr(Flush),
        .push(acc0), .push_entry(ent0), .pop(pop_alu),
        .head(head[SRC_ALU]), .full(full[SRC_ALU]), .empty(empty[SRC_ALU]),
        .entries(entries0), .valid(valid0)
    );

    wb_age_fifo #(.DEPTH(QDEPTH)) u_q_mem (
        .Clk(Clk), .Rst(Rst), .Clr(Flush),
        .push(acc1), .push_entry(ent1), .pop(pop_mem),
        .head(head[SRC_MEM]), .full(full[SRC_MEM]), .empty(empty[SRC_MEM]),
        .entries(entries1), .valid(valid1)
    );

    always_comb begin
        grant_mem = 1'b0;
        if (empty[SRC_ALU])      grant_mem = !empty[SRC_MEM];
        else if (!empty[SRC_MEM]) grant_mem = is_older(head[SRC_MEM].stamp, head[SRC_ALU].stamp);
    end

    assign pop_mem = grant_mem;
    assign pop_alu = !empty[SRC_ALU] && !grant_mem;

    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            age_cnt <= '0;
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            age_cnt <= age_cnt + SEQW'(acc0) + SEQW'(acc1);
            if (pop_mem) begin
                wr_en   <= 1'b1;
                wr_reg  <= head[SRC_MEM].rd;
                wr_data <= head[SRC_MEM].data;
            end else if (pop_alu) begin
                wr_en   <= 1'b1;
                wr_reg  <= head[SRC_ALU].rd;
                wr_data <= head[SRC_ALU].data;
            end else begin
                wr_en   <= 1'b0;
                wr_reg  <= '0;
                wr_data <= '0;
            end
        end
    end

    // Write stage is the oldest pending write, so any queued match overrides it;
    // among queued matches the youngest stamp wins.
    always_comb begin
        q_hit        = 1'b0;
        q_data       = '0;
        q_stamp      = '0;
        q_from_queue = 1'b0;
        if (bus.Query_reg != '0) begin
            if (wr_en && (wr_reg == bus.Query_reg)) begin
                q_hit  = 1'b1;
                q_data = wr_data;
            end
            for (int i = 0; i < QDEPTH; i++) begin
                if (valid0[i] && (entries0[i].rd == bus.Query_reg) &&
                    (!q_from_queue || is_older(q_stamp, entries0[i].stamp))) begin
                    q_hit        = 1'b1;
                    q_data       = entries0[i].data;
                    q_stamp      = entries0[i].stamp;
                    q_from_queue = 1'b1;
                end
            end
            for (int i = 0; i < QDEPTH; i++) begin
                if (valid1[i] && (entries1[i].rd == bus.Query_reg) &&
                    (!q_from_queue || is_older(q_stamp, entries1[i].stamp))) begin
                    q_hit        = 1'b1;
                    q_data       = entries1[i].data;
                    q_stamp      = entries1[i].stamp;
                    q_from_queue = 1'b1;
                end
            end
        end
    end

    assign bus.Src0_ready = rdy0;
    assign bus.Src1_ready = rdy1;
    assign bus.Write_en   = wr_en;
    assign bus.Write_reg  = wr_reg;
    assign bus.Write_data = wr_data;
    assign bus.Query_hit  = q_hit;
    assign bus.Query_data = q_data;
    assign bus.Busy       = (empty != 2'b11) || wr_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int QDEPTH = 2;

    logic Clk = 1'b0;
    logic Rst;
    logic Flush;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.QDEPTH(QDEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted write in global acceptance order
    // (which is age order), plus the write stage contents.
    typedef struct {
        bit          src;
        logic [4:0]  r;
        logic [31:0] d;
    } pend_t;

    pend_t       pend[$];
    int          mcnt[2];
    bit          ws_v;
    logic [4:0]  ws_r;
    logic [31:0] ws_d;

    bit          e_rdy0, e_rdy1, e_wen, e_hit, e_busy;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata, e_qd;

    function automatic void compute_expect();
        e_rdy0  = !Rst && !Flush && (mcnt[0] < QDEPTH);
        e_rdy1  = !Rst && !Flush && (mcnt[1] < QDEPTH);
        e_wen   = ws_v;
        e_wreg  = ws_v ? ws_r : 5'd0;
        e_wdata = ws_v ? ws_d : 32'd0;
        e_hit   = 1'b0;
        e_qd    = 32'd0;
        if (bus.Query_reg != 5'd0) begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].r == bus.Query_reg) begin
                    e_hit = 1'b1;
                    e_qd  = pend[i].d;
                    break;
                end
            end
            if (!e_hit && ws_v && ws_r == bus.Query_reg) begin
                e_hit = 1'b1;
                e_qd  = ws_d;
            end
        end
        e_busy = (pend.size() != 0) || ws_v;
    endfunction

    task automatic compare_model();
        compute_expect();
        chk("src0_ready", 32'(bus.Src0_ready), 32'(e_rdy0));
        chk("src1_ready", 32'(bus.Src1_ready), 32'(e_rdy1));
        chk("write_en",   32'(bus.Write_en),   32'(e_wen));
        chk("write_reg",  32'(bus.Write_reg),  32'(e_wreg));
        chk("write_data", bus.Write_data,      e_wdata);
        chk("query_hit",  32'(bus.Query_hit),  32'(e_hit));
        chk("query_data", bus.Query_data,      e_qd);
        chk("busy",       32'(bus.Busy),       32'(e_busy));
    endtask

    // Called right after the active edge; inputs are still the pre-edge values.
    task automatic model_edge();
        bit    a0, a1;
        pend_t e;
        if (Rst || Flush) begin
            pend.delete();
            mcnt[0] = 0;
            mcnt[1] = 0;
            ws_v = 1'b0; ws_r = 5'd0; ws_d = 32'd0;
        end else begin
            a1 = bus.Src1_valid && (mcnt[1] < QDEPTH) && (bus.Src1_reg != 5'd0);
            a0 = bus.Src0_valid && (mcnt[0] < QDEPTH) && (bus.Src0_reg != 5'd0);
            if (pend.size() > 0) begin
                e = pend.pop_front();
                mcnt[e.src]--;
                ws_v = 1'b1; ws_r = e.r; ws_d = e.d;
            end else begin
                ws_v = 1'b0; ws_r = 5'd0; ws_d = 32'd0;
            end
            if (a1) begin pend.push_back('{1'b1, bus.Src1_reg, bus.Src1_data}); mcnt[1]++; end
            if (a0) begin pend.push_back('{1'b0, bus.Src0_reg, bus.Src0_data}); mcnt[0]++; end
        end
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic advance();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        Flush = 1'b0;
        bus.Src0_valid = 1'b0; bus.Src0_reg = 5'd0; bus.Src0_data = 32'd0;
        bus.Src1_valid = 1'b0; bus.Src1_reg = 5'd0; bus.Src1_data = 32'd0;
    endtask

    task automatic model_cycle();
        settle();
        compare_model();
        advance();
    endtask

    typedef struct {
        bit          fl;
        bit          v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        bit          v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic [4:0]  q;
        bit          er0, er1, ewen;
        logic [4:0]  ewreg;
        logic [31:0] ewd;
        bit          ehit;
        logic [31:0] eqd;
        bit          ebusy;
    } vec_t;

    function automatic vec_t mk(bit fl, bit v0, logic [4:0] r0, logic [31:0] d0,
                                bit v1, logic [4:0] r1, logic [31:0] d1, logic [4:0] q,
                                bit er0, bit er1, bit ewen, logic [4:0] ewreg, logic [31:0] ewd,
                                bit ehit, logic [31:0] eqd, bit ebusy);
        vec_t v;
        v = '{fl, v0, r0, d0, v1, r1, d1, q, er0, er1, ewen, ewreg, ewd, ehit, eqd, ebusy};
        return v;
    endfunction

    vec_t        tbl[$];
    logic [31:0] obs[$];
    logic [31:0] acc_log[$];

    initial begin
        int  i0, i1, budget;
        bit  stall, h0, h1;

        Rst = 1'b1;
        idle_inputs();
        bus.Query_reg = 5'd0;
        mcnt[0] = 0; mcnt[1] = 0;
        ws_v = 1'b0; ws_r = 5'd0; ws_d = 32'd0;

        advance();
        settle();
        chk("rst_src0_ready", 32'(bus.Src0_ready), 32'd0);
        chk("rst_src1_ready", 32'(bus.Src1_ready), 32'd0);
        chk("rst_write_en",   32'(bus.Write_en),   32'd0);
        chk("rst_write_reg",  32'(bus.Write_reg),  32'd0);
        chk("rst_write_data", bus.Write_data,      32'd0);
        chk("rst_busy",       32'(bus.Busy),       32'd0);
        advance();
        Rst = 1'b0;

        // fl v0 r0 d0 v1 r1 d1 q | rdy0 rdy1 wen wreg wdata hit qdata busy
        tbl.push_back(mk(0,0,0,0,          0,0,0,          0, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,1,5,32'h1234,   0,0,0,          5, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          5, 1,1,0,0,0,          1,32'h1234,   1));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          5, 1,1,1,5,32'h1234,   1,32'h1234,   1));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          5, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,1,3,32'hAAAA,   1,3,32'hBBBB,   3, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          3, 1,1,0,0,0,          1,32'hAAAA,   1));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          3, 1,1,1,3,32'hBBBB,   1,32'hAAAA,   1));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          3, 1,1,1,3,32'hAAAA,   1,32'hAAAA,   1));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          3, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,1,0,32'hFFFF,   0,0,0,          0, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          0, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,1,7,32'h11,     0,0,0,          7, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,1,7,32'h22,     0,0,0,          7, 1,1,0,0,0,          1,32'h11,     1));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          7, 1,1,1,7,32'h11,     1,32'h22,     1));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          7, 1,1,1,7,32'h22,     1,32'h22,     1));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          7, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,1,4,32'h44,     1,6,32'h66,     4, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(1,1,9,32'h99,     0,0,0,          4, 0,0,0,0,0,          1,32'h44,     1));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          4, 1,1,0,0,0,          0,0,          0));
        tbl.push_back(mk(0,0,0,0,          0,0,0,          9, 1,1,0,0,0,          0,0,          0));

        foreach (tbl[i]) begin
            Flush = tbl[i].fl;
            bus.Src0_valid = tbl[i].v0; bus.Src0_reg = tbl[i].r0; bus.Src0_data = tbl[i].d0;
            bus.Src1_valid = tbl[i].v1; bus.Src1_reg = tbl[i].r1; bus.Src1_data = tbl[i].d1;
            bus.Query_reg  = tbl[i].q;
            settle();
            chk($sformatf("tbl%0d_src0_ready", i), 32'(bus.Src0_ready), 32'(tbl[i].er0));
            chk($sformatf("tbl%0d_src1_ready", i), 32'(bus.Src1_ready), 32'(tbl[i].er1));
            chk($sformatf("tbl%0d_write_en", i),   32'(bus.Write_en),   32'(tbl[i].ewen));
            chk($sformatf("tbl%0d_write_reg", i),  32'(bus.Write_reg),  32'(tbl[i].ewreg));
            chk($sformatf("tbl%0d_write_data", i), bus.Write_data,      tbl[i].ewd);
            chk($sformatf("tbl%0d_query_hit", i),  32'(bus.Query_hit),  32'(tbl[i].ehit));
            chk($sformatf("tbl%0d_query_data", i), bus.Query_data,      tbl[i].eqd);
            chk($sformatf("tbl%0d_busy", i),       32'(bus.Busy),       32'(tbl[i].ebusy));
            advance();
        end
        idle_inputs();

        // Both sources held valid for 8 items each; queues must fill and stall.
        bus.Query_reg = 5'd0;
        repeat (3) model_cycle();
        obs.delete();
        acc_log.delete();
        i0 = 0; i1 = 0; stall = 1'b0;
        for (budget = 0; budget < 60 && (i0 < 8 || i1 < 8 || pend.size() != 0 || ws_v); budget++) begin
            bus.Src0_valid = (i0 < 8); bus.Src0_reg = 5'((i0 % 7) + 1); bus.Src0_data = 32'hA000 + 32'(i0);
            bus.Src1_valid = (i1 < 8); bus.Src1_reg = 5'((i1 % 5) + 2); bus.Src1_data = 32'hB000 + 32'(i1);
            settle();
            compare_model();
            if (bus.Write_en) obs.push_back(bus.Write_data);
            if ((bus.Src0_valid && !bus.Src0_ready) || (bus.Src1_valid && !bus.Src1_ready)) stall = 1'b1;
            h0 = bus.Src0_valid && bus.Src0_ready;
            h1 = bus.Src1_valid && bus.Src1_ready;
            advance();
            if (h1) begin acc_log.push_back(bus.Src1_data); i1++; end
            if (h0) begin acc_log.push_back(bus.Src0_data); i0++; end
            if (i0 >= 8) bus.Src0_valid = 1'b0;
            if (i1 >= 8) bus.Src1_valid = 1'b0;
        end
        idle_inputs();
        chk("t4_within_budget", 32'(budget < 60), 32'd1);
        chk("t4_ready_deasserted", 32'(stall), 32'd1);
        chk("t4_write_count", 32'(obs.size()), 32'd16);
        foreach (acc_log[k]) begin
            if (k < obs.size()) chk($sformatf("t4_order%0d", k), obs[k], acc_log[k]);
        end

        // Flush with three pending writes, then check ordering restarts cleanly.
        bus.Src0_valid = 1'b1; bus.Src0_reg = 5'd1; bus.Src0_data = 32'h61;
        bus.Src1_valid = 1'b1; bus.Src1_reg = 5'd2; bus.Src1_data = 32'h62;
        bus.Query_reg  = 5'd1;
        model_cycle();
        bus.Src0_reg = 5'd3; bus.Src0_data = 32'h63; bus.Src1_valid = 1'b0;
        model_cycle();
        Flush = 1'b1; bus.Src0_reg = 5'd4; bus.Src0_data = 32'h64;
        settle();
        chk("t6_busy_before_flush", 32'(bus.Busy), 32'd1);
        chk("t6_ready_during_flush", 32'(bus.Src0_ready), 32'd0);
        compare_model();
        advance();
        idle_inputs();
        settle();
        chk("t6_write_en_after_flush", 32'(bus.Write_en), 32'd0);
        chk("t6_busy_after_flush", 32'(bus.Busy), 32'd0);
        chk("t6_hit_after_flush", 32'(bus.Query_hit), 32'd0);
        compare_model();
        advance();

        bus.Src0_valid = 1'b1; bus.Src0_reg = 5'd5; bus.Src0_data = 32'h75;
        bus.Src1_valid = 1'b1; bus.Src1_reg = 5'd5; bus.Src1_data = 32'h76;
        bus.Query_reg  = 5'd5;
        model_cycle();
        idle_inputs();
        model_cycle();
        settle();
        chk("t6_first_after_flush", bus.Write_data, 32'h76);
        compare_model();
        advance();
        settle();
        chk("t6_second_after_flush", bus.Write_data, 32'h75);
        compare_model();
        advance();

        bus.Src0_valid = 1'b1; bus.Src0_reg = 5'd6; bus.Src0_data = 32'h86;
        bus.Src1_valid = 1'b1; bus.Src1_reg = 5'd7; bus.Src1_data = 32'h87;
        bus.Query_reg  = 5'd6;
        model_cycle();
        Rst = 1'b1; bus.Src1_valid = 1'b0; bus.Src0_reg = 5'd8;
        settle();
        chk("t6_ready0_in_reset", 32'(bus.Src0_ready), 32'd0);
        chk("t6_ready1_in_reset", 32'(bus.Src1_ready), 32'd0);
        compare_model();
        advance();
        Rst = 1'b0;
        idle_inputs();
        settle();
        chk("t6_write_en_after_rst", 32'(bus.Write_en), 32'd0);
        chk("t6_busy_after_rst", 32'(bus.Busy), 32'd0);
        chk("t6_hit_after_rst", 32'(bus.Query_hit), 32'd0);
        compare_model();
        advance();

        // Random traffic against the model, with occasional flush and reset.
        for (int c = 0; c < 2000; c++) begin
            Rst   = ($urandom_range(0, 199) == 0);
            Flush = ($urandom_range(0, 49) == 0);
            bus.Src0_valid = ($urandom_range(0, 9) < 6);
            bus.Src0_reg   = 5'($urandom_range(0, 7));
            bus.Src0_data  = $urandom;
            bus.Src1_valid = ($urandom_range(0, 9) < 6);
            bus.Src1_reg   = 5'($urandom_range(0, 7));
            bus.Src1_data  = $urandom;
            bus.Query_reg  = 5'($urandom_range(0, 7));
            model_cycle();
        end
        Rst = 1'b0;
        idle_inputs();
        repeat (6) model_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
